// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel divides Clk by a runtime-loadable divisor applied at its terminal count.
module prog_clk_div #(
  parameter int NumCh    = 2,
  parameter int ChSelW   = 1,
  parameter int CntWidth = 25,
  parameter int DefDiv   = 1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [NumCh-1:0]    En,
  input  logic                Align,
  input  logic                WrEn,
  input  logic [ChSelW-1:0]   WrCh,
  input  logic [CntWidth-1:0] WrData,
  output logic [NumCh-1:0]    ClkOut,
  output logic [NumCh-1:0]    TickOut,
  output logic [NumCh-1:0]    Pending
);

  logic [CntWidth-1:0] cnt_q    [NumCh];
  logic [CntWidth-1:0] cnt_d    [NumCh];
  logic [CntWidth-1:0] div_q    [NumCh];
  logic [CntWidth-1:0] div_d    [NumCh];
  logic [CntWidth-1:0] shadow_q [NumCh];
  logic [CntWidth-1:0] shadow_d [NumCh];
  logic [NumCh-1:0]    pend_q, pend_d;
  logic [NumCh-1:0]    clk_q, clk_d;
  logic [NumCh-1:0]    tick_q, tick_d;

  logic [CntWidth-1:0] eff      [NumCh];
  logic [NumCh-1:0]    tc;
  logic [NumCh-1:0]    wr_hit;
  logic [NumCh-1:0]    apply;

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    clk_d    = clk_q;
    tick_d   = tick_q;
    tc       = '0;
    wr_hit   = '0;
    apply    = '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      eff[i]    = (div_q[i] == '0) ? CntWidth'(1) : div_q[i];
      tc[i]     = En[i] && (cnt_q[i] == eff[i] - CntWidth'(1));
      wr_hit[i] = WrEn && (WrCh == ChSelW'(i));
      apply[i]  = !En[i] || Align || tc[i];

      if (!En[i] || Align) begin
        cnt_d[i]  = '0;
        clk_d[i]  = 1'b0;
        tick_d[i] = 1'b0;
      end else if (tc[i]) begin
        cnt_d[i]  = '0;
        clk_d[i]  = ~clk_q[i];
        tick_d[i] = 1'b1;
      end else begin
        cnt_d[i]  = cnt_q[i] + CntWidth'(1);
        tick_d[i] = 1'b0;
      end

      // A write on an apply cycle only updates the shadow; the older shadow
      // value (if pending) still loads into Div this edge.
      if (apply[i] && pend_q[i]) begin
        div_d[i]  = shadow_q[i];
        pend_d[i] = 1'b0;
      end
      if (wr_hit[i]) begin
        shadow_d[i] = WrData;
        pend_d[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int unsigned i = 0; i < NumCh; i++) begin
        cnt_q[i]    <= '0;
        div_q[i]    <= CntWidth'(DefDiv);
        shadow_q[i] <= CntWidth'(DefDiv);
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign ClkOut  = clk_q;
  assign TickOut = tick_q;
  assign Pending = pend_q;

endmodule
